// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Brief    : VGA 640x480@60 timing constants, game geometry, shared types and
//            small helpers for the Pong demo.
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam logic [9:0] H_VIS        = 10'd640;
    localparam logic [9:0] H_FP         = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BP         = 10'd48;
    localparam logic [9:0] H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] H_SYNC_START = H_VIS + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam logic [9:0] V_VIS        = 10'd480;
    localparam logic [9:0] V_FP         = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BP         = 10'd33;
    localparam logic [9:0] V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] V_SYNC_START = V_VIS + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef logic signed [10:0] coord_t;
    typedef struct packed {
        coord_t x;
        coord_t y;
    } pos_t;
    typedef logic [3:0] score_t;

    localparam coord_t PAD_W         = 11'sd8;
    localparam coord_t PAD_H         = 11'sd64;
    localparam coord_t PAD_HALF      = 11'sd32;
    localparam coord_t PAD_L_X       = 11'sd16;
    localparam coord_t PAD_R_X       = 11'sd616;
    localparam coord_t PAD_Y_MAX     = 11'sd416;
    localparam coord_t PAD_Y_RST     = 11'sd208;
    localparam coord_t BALL_SZ       = 11'sd8;
    localparam coord_t BALL_HALF     = 11'sd4;
    localparam coord_t BALL_X_RST    = 11'sd316;
    localparam coord_t BALL_Y_RST    = 11'sd236;
    localparam coord_t BALL_Y_MAX    = 11'sd472;
    localparam coord_t BALL_X_L_HIT  = 11'sd24;
    localparam coord_t BALL_X_R_HIT  = 11'sd608;
    localparam coord_t BALL_X_R_MISS = 11'sd632;
    localparam coord_t AI_DEADBAND   = 11'sd4;

    function automatic score_t score_inc(input score_t s);
        return (s == 4'd9) ? 4'd0 : s + 4'd1;
    endfunction

    function automatic logic y_overlap(input coord_t ball_y, input coord_t pad_y);
        return (ball_y < pad_y + PAD_H) && (ball_y + BALL_SZ > pad_y);
    endfunction

    function automatic logic in_rect(input coord_t px, input coord_t py,
                                     input coord_t rx, input coord_t ry,
                                     input coord_t w,  input coord_t h);
        return (px >= rx) && (px < rx + w) && (py >= ry) && (py < ry + h);
    endfunction

    // Pressing both directions cancels; result is clamped to the playfield.
    function automatic coord_t pad_next(input coord_t y, input logic up,
                                        input logic dn, input coord_t step);
        coord_t t;
        t = y;
        if (up && !dn) begin
            t = y - step;
            if (t[10]) t = '0;
        end else if (dn && !up) begin
            t = y + step;
            if (t > PAD_Y_MAX) t = PAD_Y_MAX;
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : pong_vga_timing
// Brief    : Pixel-tick divider, 800x525 raster counters, registered active-low
//            syncs and visible-area flag.
// Revision : 1.0 - initial release
// ============================================================================
module pong_vga_timing
    import pong_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       o_tick,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_visible,
    output logic       o_hs,
    output logic       o_vs
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic             r_hs;
    logic             r_vs;
    logic             w_tick;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                if (r_h == H_TOTAL - 10'd1) begin
                    r_h <= '0;
                    r_v <= (r_v == V_TOTAL - 10'd1) ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
            // Syncs follow the counters by one system clock.
            r_hs <= !((r_h >= H_SYNC_START) && (r_h < H_SYNC_END));
            r_vs <= !((r_v >= V_SYNC_START) && (r_v < V_SYNC_END));
        end
    end

    assign o_tick    = w_tick;
    assign o_x       = r_h;
    assign o_y       = r_v;
    assign o_visible = (r_h < H_VIS) && (r_v < V_VIS);
    assign o_hs      = r_hs;
    assign o_vs      = r_vs;

endmodule
`default_nettype wire

// File: rtl/pong_game_top.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_top
// Brief    : Pong demo top: VGA timing, per-frame paddle/ball/score update and
//            white-on-black renderer. Define PONG_AI_EN for a CPU right paddle.
// Revision : 1.0 - initial release
// ============================================================================
module pong_game_top
    import pong_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int PAD_SPEED  = 4,
    parameter int BALL_SPEED = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_l_up_i,
    input  logic       btn_l_dn_i,
    input  logic       btn_r_up_i,
    input  logic       btn_r_dn_i,
    output logic       vga_hs_o,
    output logic       vga_vs_o,
    output logic [3:0] vga_r_o,
    output logic [3:0] vga_g_o,
    output logic [3:0] vga_b_o,
    output score_t     score_l_o,
    output score_t     score_r_o
);

    localparam coord_t c_pad_step  = coord_t'(PAD_SPEED);
    localparam coord_t c_ball_step = coord_t'(BALL_SPEED);

    logic       w_tick, w_visible;
    logic [9:0] w_x, w_y;

    pong_vga_timing #(.CLK_DIV(CLK_DIV)) u_vga (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .o_tick    (w_tick),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_visible (w_visible),
        .o_hs      (vga_hs_o),
        .o_vs      (vga_vs_o)
    );

    pos_t   r_ball;
    logic   r_dx_neg, r_dy_neg;
    coord_t r_pad_l_y, r_pad_r_y;
    score_t r_score_l, r_score_r;
    logic [3:0] r_rgb;

    // Current-state views read by the game logic and renderer.
    pos_t   w_ball;
    logic   w_dx_neg, w_dy_neg;
    coord_t w_pad_l_y, w_pad_r_y;
    assign w_ball    = r_ball;
    assign w_dx_neg  = r_dx_neg;
    assign w_dy_neg  = r_dy_neg;
    assign w_pad_l_y = r_pad_l_y;
    assign w_pad_r_y = r_pad_r_y;

    logic w_frame_upd;
    assign w_frame_upd = w_tick && (w_x == 10'd0) && (w_y == V_VIS);

    logic w_r_up, w_r_dn;
`ifdef PONG_AI_EN
    coord_t w_ai_pad_c, w_ai_ball_c;
    logic   w_unused_btn_r;
    assign w_ai_pad_c     = w_pad_r_y + PAD_HALF;
    assign w_ai_ball_c    = w_ball.y + BALL_HALF;
    assign w_r_up         = w_ai_pad_c > w_ai_ball_c + AI_DEADBAND;
    assign w_r_dn         = w_ai_pad_c + AI_DEADBAND < w_ai_ball_c;
    assign w_unused_btn_r = btn_r_up_i ^ btn_r_dn_i;
`else
    assign w_r_up = btn_r_up_i;
    assign w_r_dn = btn_r_dn_i;
`endif

    pos_t   w_ball_nxt;
    logic   w_dx_nxt, w_dy_nxt;
    score_t w_score_l_nxt, w_score_r_nxt;

    always_comb begin
        w_ball_nxt.x  = w_ball.x + (w_dx_neg ? -c_ball_step : c_ball_step);
        w_ball_nxt.y  = w_ball.y + (w_dy_neg ? -c_ball_step : c_ball_step);
        w_dx_nxt      = w_dx_neg;
        w_dy_nxt      = w_dy_neg;
        w_score_l_nxt = r_score_l;
        w_score_r_nxt = r_score_r;

        if (w_ball_nxt.y <= 11'sd0) begin
            w_ball_nxt.y = '0;
            w_dy_nxt     = 1'b0;
        end else if (w_ball_nxt.y >= BALL_Y_MAX) begin
            w_ball_nxt.y = BALL_Y_MAX;
            w_dy_nxt     = 1'b1;
        end

        // A paddle return wins over a miss evaluated in the same frame.
        if (w_dx_neg && (w_ball_nxt.x <= BALL_X_L_HIT) && y_overlap(w_ball_nxt.y, w_pad_l_y)) begin
            w_ball_nxt.x = BALL_X_L_HIT;
            w_dx_nxt     = 1'b0;
        end else if (!w_dx_neg && (w_ball_nxt.x >= BALL_X_R_HIT) && y_overlap(w_ball_nxt.y, w_pad_r_y)) begin
            w_ball_nxt.x = BALL_X_R_HIT;
            w_dx_nxt     = 1'b1;
        end else if (w_ball_nxt.x <= 11'sd0) begin
            w_score_r_nxt = score_inc(r_score_r);
            w_ball_nxt.x  = BALL_X_RST;
            w_ball_nxt.y  = BALL_Y_RST;
            w_dx_nxt      = 1'b1;
        end else if (w_ball_nxt.x >= BALL_X_R_MISS) begin
            w_score_l_nxt = score_inc(r_score_l);
            w_ball_nxt.x  = BALL_X_RST;
            w_ball_nxt.y  = BALL_Y_RST;
            w_dx_nxt      = 1'b0;
        end
    end

    coord_t w_px, w_py;
    logic   w_on_obj;
    assign w_px     = coord_t'({1'b0, w_x});
    assign w_py     = coord_t'({1'b0, w_y});
    assign w_on_obj = in_rect(w_px, w_py, PAD_L_X, w_pad_l_y, PAD_W, PAD_H)
                   || in_rect(w_px, w_py, PAD_R_X, w_pad_r_y, PAD_W, PAD_H)
                   || in_rect(w_px, w_py, w_ball.x, w_ball.y, BALL_SZ, BALL_SZ);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ball.x  <= BALL_X_RST;
            r_ball.y  <= BALL_Y_RST;
            r_dx_neg  <= 1'b0;
            r_dy_neg  <= 1'b0;
            r_pad_l_y <= PAD_Y_RST;
            r_pad_r_y <= PAD_Y_RST;
            r_score_l <= '0;
            r_score_r <= '0;
            r_rgb     <= '0;
        end else begin
            if (w_frame_upd) begin
                r_ball    <= w_ball_nxt;
                r_dx_neg  <= w_dx_nxt;
                r_dy_neg  <= w_dy_nxt;
                r_pad_l_y <= pad_next(w_pad_l_y, btn_l_up_i, btn_l_dn_i, c_pad_step);
                r_pad_r_y <= pad_next(w_pad_r_y, w_r_up, w_r_dn, c_pad_step);
                r_score_l <= w_score_l_nxt;
                r_score_r <= w_score_r_nxt;
            end
            r_rgb <= (w_visible && w_on_obj) ? 4'hF : 4'h0;
        end
    end

    assign vga_r_o   = r_rgb;
    assign vga_g_o   = r_rgb;
    assign vga_b_o   = r_rgb;
    assign score_l_o = r_score_l;
    assign score_r_o = r_score_r;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_game_top
// Brief    : Directed, table-driven bench for pong_game_top; frame updates are
//            strobed directly so many frames fit in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_game_top;
    import pong_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_lu = 1'b0, b_ld = 1'b0, b_ru = 1'b0, b_rd = 1'b0;
    logic       hs, vs;
    logic [3:0] r, g, b;
    score_t     sl, sr;

    always #5 clk = ~clk;

    pong_game_top dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .btn_l_up_i (b_lu),
        .btn_l_dn_i (b_ld),
        .btn_r_up_i (b_ru),
        .btn_r_dn_i (b_rd),
        .vga_hs_o   (hs),
        .vga_vs_o   (vs),
        .vga_r_o    (r),
        .vga_g_o    (g),
        .vga_b_o    (b),
        .score_l_o  (sl),
        .score_r_o  (sr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [10:0] f_x, f_y;
    logic               f_dxn, f_dyn;

    typedef struct {
        logic lu, ld, ru, rd;
        int   frames;
        int   exp_l;
        int   exp_r;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task frame();
        @(negedge clk);
        force dut.w_frame_upd = 1'b1;
        @(negedge clk);
        release dut.w_frame_upd;
    endtask

    task forced_frame(input logic signed [10:0] x, input logic signed [10:0] y,
                      input logic dxn, input logic dyn);
        f_x = x; f_y = y; f_dxn = dxn; f_dyn = dyn;
        @(negedge clk);
        force dut.w_ball      = {f_x, f_y};
        force dut.w_dx_neg    = f_dxn;
        force dut.w_dy_neg    = f_dyn;
        force dut.w_frame_upd = 1'b1;
        @(negedge clk);
        release dut.w_ball;
        release dut.w_dx_neg;
        release dut.w_dy_neg;
        release dut.w_frame_upd;
    endtask

    task automatic wait_pix(input int x, input int y, input logic [3:0] exp, input string nm);
        bit found = 1'b0;
        for (int k = 0; k < 4000 && !found; k++) begin
            @(posedge clk); #1;
            if (dut.u_vga.o_x == x[9:0] && dut.u_vga.o_y == y[9:0]) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: pixel (%0d,%0d) not reached, expected %0d", nm, x, y, exp);
        end else begin
            @(posedge clk); #1;
            chk(nm, {20'd0, r, g, b}, {20'd0, exp, exp, exp});
        end
    endtask

    initial begin
        int first_fall, first_rise, second_fall, vs_low;
        logic prev_hs;

        vecs[0] = '{lu:0, ld:0, ru:0, rd:0, frames:1,   exp_l:208, exp_r:208};
        vecs[1] = '{lu:1, ld:0, ru:0, rd:0, frames:1,   exp_l:204, exp_r:208};
        vecs[2] = '{lu:1, ld:1, ru:0, rd:0, frames:1,   exp_l:204, exp_r:208};
        vecs[3] = '{lu:0, ld:0, ru:0, rd:1, frames:3,   exp_l:204, exp_r:220};
        vecs[4] = '{lu:0, ld:1, ru:0, rd:0, frames:2,   exp_l:212, exp_r:220};
        vecs[5] = '{lu:1, ld:0, ru:0, rd:0, frames:60,  exp_l:0,   exp_r:220};
        vecs[6] = '{lu:0, ld:1, ru:0, rd:0, frames:120, exp_l:416, exp_r:220};
        vecs[7] = '{lu:0, ld:0, ru:1, rd:0, frames:100, exp_l:416, exp_r:0};
        vecs[8] = '{lu:0, ld:0, ru:1, rd:1, frames:5,   exp_l:416, exp_r:0};
        vecs[9] = '{lu:0, ld:1, ru:0, rd:1, frames:1,   exp_l:416, exp_r:4};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hs", 32'(hs), 1);
        chk("rst_vs", 32'(vs), 1);
        chk("rst_rgb", {20'd0, r, g, b}, 0);
        chk("rst_score_l", 32'(sl), 0);
        chk("rst_score_r", 32'(sr), 0);
        chk("rst_ball_x", 32'(dut.r_ball.x), 316);
        chk("rst_ball_y", 32'(dut.r_ball.y), 236);
        chk("rst_pad_l", 32'(dut.r_pad_l_y), 208);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Free-running sync timing
        first_fall = -1; first_rise = -1; second_fall = -1; vs_low = 0;
        prev_hs = 1'b1;
        for (int cyc = 1; cyc <= 10000; cyc++) begin
            @(posedge clk); #1;
            if (prev_hs && !hs) begin
                if (first_fall < 0) first_fall = cyc;
                else if (second_fall < 0) second_fall = cyc;
            end
            if (!prev_hs && hs && first_fall >= 0 && first_rise < 0) first_rise = cyc;
            if (!vs) vs_low++;
            prev_hs = hs;
        end
        chk("hs_first_fall", 32'(first_fall), 2625);
        chk("hs_low_width", 32'(first_rise - first_fall), 384);
        chk("hs_period", 32'(second_fall - first_fall), 3200);
        chk("vs_low_cycles", 32'(vs_low), 0);

        // One frame, no buttons
        do_reset(2);
        frame();
        chk("f1_ball_x", 32'(dut.r_ball.x), 318);
        chk("f1_ball_y", 32'(dut.r_ball.y), 238);
        chk("f1_pad_l", 32'(dut.r_pad_l_y), 208);
        chk("f1_pad_r", 32'(dut.r_pad_r_y), 208);

        // Paddle vectors
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            b_lu = vecs[i].lu; b_ld = vecs[i].ld; b_ru = vecs[i].ru; b_rd = vecs[i].rd;
            repeat (vecs[i].frames) frame();
            b_lu = 1'b0; b_ld = 1'b0; b_ru = 1'b0; b_rd = 1'b0;
            chk($sformatf("vec%0d_pad_l", i), 32'(dut.r_pad_l_y), 32'(vecs[i].exp_l));
`ifndef PONG_AI_EN
            chk($sformatf("vec%0d_pad_r", i), 32'(dut.r_pad_r_y), 32'(vecs[i].exp_r));
`endif
        end

        // Left miss from (8,100) moving left
        do_reset(2);
        forced_frame(11'sd8, 11'sd100, 1'b1, 1'b0);
        frame();
        frame();
        chk("lmiss_pre_x", 32'(dut.r_ball.x), 2);
        chk("lmiss_pre_score_r", 32'(sr), 0);
        frame();
        chk("lmiss_score_r", 32'(sr), 1);
        chk("lmiss_score_l", 32'(sl), 0);
        chk("lmiss_ball_x", 32'(dut.r_ball.x), 316);
        chk("lmiss_ball_y", 32'(dut.r_ball.y), 236);
        chk("lmiss_dx_neg", 32'(dut.r_dx_neg), 1);
        chk("lmiss_dy_neg", 32'(dut.r_dy_neg), 0);

        // Right miss
        forced_frame(11'sd628, 11'sd100, 1'b0, 1'b0);
        chk("rmiss_pre_x", 32'(dut.r_ball.x), 630);
        chk("rmiss_pre_score_l", 32'(sl), 0);
        frame();
        chk("rmiss_score_l", 32'(sl), 1);
        chk("rmiss_ball_x", 32'(dut.r_ball.x), 316);
        chk("rmiss_dx_neg", 32'(dut.r_dx_neg), 0);

        // Paddle returns
        forced_frame(11'sd26, 11'sd220, 1'b1, 1'b0);
        chk("lhit_x", 32'(dut.r_ball.x), 24);
        chk("lhit_dx_neg", 32'(dut.r_dx_neg), 0);
        chk("lhit_score_r", 32'(sr), 1);
        forced_frame(11'sd606, 11'sd200, 1'b0, 1'b0);
        chk("rhit_x", 32'(dut.r_ball.x), 608);
        chk("rhit_dx_neg", 32'(dut.r_dx_neg), 1);
        forced_frame(11'sd606, 11'sd198, 1'b0, 1'b0);
        chk("rgraze_x", 32'(dut.r_ball.x), 608);
        chk("rgraze_dx_neg", 32'(dut.r_dx_neg), 0);

        // Wall bounces
        forced_frame(11'sd300, 11'sd2, 1'b0, 1'b1);
        chk("top_y", 32'(dut.r_ball.y), 0);
        chk("top_dy_neg", 32'(dut.r_dy_neg), 0);
        forced_frame(11'sd300, 11'sd470, 1'b0, 1'b0);
        chk("bot_y", 32'(dut.r_ball.y), 472);
        chk("bot_dy_neg", 32'(dut.r_dy_neg), 1);
        forced_frame(11'sd300, 11'sd468, 1'b0, 1'b0);
        chk("nearbot_y", 32'(dut.r_ball.y), 470);
        chk("nearbot_dy_neg", 32'(dut.r_dy_neg), 0);

        // Score wrap 9 -> 0
        repeat (8) forced_frame(11'sd2, 11'sd100, 1'b1, 1'b0);
        chk("score_r_nine", 32'(sr), 9);
        forced_frame(11'sd2, 11'sd100, 1'b1, 1'b0);
        chk("score_r_wrap", 32'(sr), 0);

        // Mid-run reset
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_score_l", 32'(sl), 0);
        chk("mid_rst_ball_x", 32'(dut.r_ball.x), 316);
        chk("mid_rst_hcnt", 32'(dut.u_vga.o_x), 0);
        @(negedge clk);
        rst = 1'b0;

        // Rendering on line 1 with both paddles at the top
        do_reset(2);
        b_lu = 1'b1; b_ru = 1'b1;
        repeat (60) frame();
        b_lu = 1'b0; b_ru = 1'b0;
        chk("pix_pad_l_top", 32'(dut.r_pad_l_y), 0);
        wait_pix(20, 1, 4'hF, "pix_pad_l");
        wait_pix(24, 1, 4'h0, "pix_right_of_pad_l");
`ifndef PONG_AI_EN
        wait_pix(620, 1, 4'hF, "pix_pad_r");
`endif
        wait_pix(624, 1, 4'h0, "pix_right_of_pad_r");

`ifdef PONG_AI_EN
        do_reset(2);
        forced_frame(11'sd300, 11'sd0, 1'b0, 1'b1);
        chk("ai_pad_r", 32'(dut.r_pad_r_y), 204);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
